// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with locked bursts for the single-port dmem
// Grant is combinational; responses are registered one cycle after acceptance.
module dmem_arbiter #(
  parameter int MEM_SIZE  = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  localparam logic [7:0]  MAX_B    = 8'(MAX_BURST);
  localparam logic [31:0] MEM_TOP  = 32'(MEM_SIZE);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  burst_q, burst_d;
  logic        gnt0, gnt1;
  logic        own0, own1;

  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        err0_q, err1_q;

  logic        any_gnt, sel_we, in_range;
  logic [31:0] sel_addr, sel_wdata, resp_data;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = ARB;
    burst_d = 8'd0;
    last_d  = last_q;
    own0    = (state_q == LOCK0) && p0_req;
    own1    = (state_q == LOCK1) && p1_req;
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (own0 || own1) begin
      // Owner keeps the memory until it drops lock or the burst limit is hit.
      gnt0    = own0;
      gnt1    = own1;
      last_d  = own1;
      burst_d = burst_q + 8'd1;
      if ((own1 ? p1_lock : p0_lock) && (burst_d != MAX_B)) begin
        state_d = state_q;
      end else begin
        burst_d = 8'd0;
      end
    end else begin
      if (p0_req && p1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
      if (gnt0 || gnt1) begin
        last_d = gnt1;
        if ((gnt1 ? p1_lock : p0_lock) && (MAX_BURST > 1)) begin
          state_d = gnt1 ? LOCK1 : LOCK0;
          burst_d = 8'd1;
        end
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? p1_we : p0_we;
  assign sel_addr  = gnt1 ? p1_addr : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign in_range  = sel_addr < MEM_TOP;

  // Out-of-range accesses are still accepted but never reach the memory.
  assign mem_we    = any_gnt & sel_we & in_range;
  assign mem_a     = (any_gnt && in_range) ? sel_addr : 32'd0;
  assign mem_wd    = any_gnt ? sel_wdata : 32'd0;
  assign resp_data = (in_range && !sel_we) ? mem_rd : 32'd0;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign p0_err    = err0_q;
  assign p1_err    = err1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB;
      last_q    <= 1'b1;
      burst_q   <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rdata0_q <= resp_data;
        err0_q   <= !in_range;
      end
      if (gnt1) begin
        rdata1_q <= resp_data;
        err1_q   <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_a[5:0]] = mem_wd;
  assign mem_rd = mem[mem_a[5:0]];

  dmem_arbiter #(.MEM_SIZE(64), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5]  = 32'hDEADBEEF;
    mem[10] = 32'hA0A0A0A0;
    mem[11] = 32'hB1B1B1B1;
    mem[20] = 32'h00000055;

    // reset: requests ignored, outputs quiet
    idle();
    reset = 1'b0;
    p0_req = 1; p0_we = 1; p0_addr = 3; p0_wdata = 32'h77;
    #2;
    chk("rst_gnt0", p0_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid0", p0_rvalid, 0);
    chk("rst_rdata1", p1_rdata, 0);
    step();
    chk("rst_no_write", mem[3], 0);
    do_reset();

    // single read
    p0_req = 1; p0_addr = 5;
    #1;
    chk("rd_gnt0", p0_gnt, 1);
    chk("rd_mem_a", mem_a, 5);
    step();
    p0_req = 0;
    chk("rd_rvalid0", p0_rvalid, 1);
    chk("rd_rdata0", p0_rdata, 32'hDEADBEEF);
    chk("rd_err0", p0_err, 0);
    chk("rd_rvalid1", p1_rvalid, 0);
    step();
    chk("rd_pulse", p0_rvalid, 0);

    // contention after reset: 0,1,0,1
    do_reset();
    p0_req = 1; p0_addr = 10; p1_req = 1; p1_addr = 11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie_gnt0_%0d", i), p0_gnt, (i % 2 == 0));
      chk($sformatf("tie_gnt1_%0d", i), p1_gnt, (i % 2 == 1));
      step();
      if (i % 2 == 0) begin
        chk($sformatf("tie_rv0_%0d", i), {p0_rvalid, p1_rvalid}, 2'b10);
        chk($sformatf("tie_rd0_%0d", i), p0_rdata, 32'hA0A0A0A0);
      end else begin
        chk($sformatf("tie_rv1_%0d", i), {p0_rvalid, p1_rvalid}, 2'b01);
        chk($sformatf("tie_rd1_%0d", i), p1_rdata, 32'hB1B1B1B1);
      end
    end

    // locked burst of 4 writes from p0 while p1 waits
    p0_we = 1; p0_lock = 1; p1_addr = 20;
    for (int k = 0; k < 4; k++) begin
      p0_addr = k; p0_wdata = k + 1;
      #1;
      chk($sformatf("burst_gnt0_%0d", k), p0_gnt, 1);
      chk($sformatf("burst_gnt1_%0d", k), p1_gnt, 0);
      chk($sformatf("burst_we_%0d", k), mem_we, 1);
      step();
    end
    p0_addr = 4; p0_wdata = 5;
    #1;
    chk("burst_end_gnt1", p1_gnt, 1);
    chk("burst_end_gnt0", p0_gnt, 0);
    step();
    chk("burst_p1_rvalid", p1_rvalid, 1);
    chk("burst_p1_rdata", p1_rdata, 32'h55);
    p1_req = 0; p0_lock = 0;
    #1;
    chk("burst_tail_gnt0", p0_gnt, 1);
    step();
    idle();
    for (int k = 0; k < 5; k++) begin
      p0_req = 1; p0_addr = k;
      step();
      chk($sformatf("readback_%0d", k), p0_rdata, k + 1);
    end
    idle();

    // out-of-range write from p1
    p1_req = 1; p1_we = 1; p1_addr = 64; p1_wdata = 32'h1234;
    #1;
    chk("oor_gnt1", p1_gnt, 1);
    chk("oor_mem_we", mem_we, 0);
    chk("oor_mem_a", mem_a, 0);
    step();
    idle();
    chk("oor_rvalid1", p1_rvalid, 1);
    chk("oor_err1", p1_err, 1);
    chk("oor_rdata1", p1_rdata, 0);
    chk("oor_mem0", mem[0], 1);

    // lock release when owner drops req
    p0_req = 1; p0_lock = 1; p0_addr = 0;
    step();
    p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 1;
    #1;
    chk("rel_gnt1", p1_gnt, 1);
    chk("rel_gnt0", p0_gnt, 0);
    step();
    idle();
    chk("rel_rdata1", p1_rdata, 2);
    chk("rel_err1", p1_err, 0);

    // async reset in the middle of a p0 lock
    p0_req = 1; p0_lock = 1; p0_addr = 2;
    step();
    chk("arst_pre_rv0", p0_rvalid, 1);
    chk("arst_pre_rd0", p0_rdata, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rv0", p0_rvalid, 0);
    chk("arst_rd0", p0_rdata, 0);
    chk("arst_rd1", p1_rdata, 0);
    chk("arst_gnt0", p0_gnt, 0);
    chk("arst_mem_we", mem_we, 0);
    #1;
    reset = 1'b1;
    p0_lock = 0; p1_req = 1; p1_addr = 1;
    #1;
    chk("arst_tie_gnt0", p0_gnt, 1);
    chk("arst_tie_gnt1", p1_gnt, 0);
    step();
    chk("arst_after_rd0", p0_rdata, 3);
    #1;
    chk("arst_next_gnt1", p1_gnt, 1);
    step();
    idle();
    chk("arst_next_rd1", p1_rdata, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (`dmem`). Two requesters share one memory: port 0 is the core load/store unit and port 1 is a secondary master (DMA/debug loader). The block selects one access per cycle with round-robin fairness, supports bounded locked bursts, blocks out-of-range writes, and returns a registered response one cycle after each grant.

## Interface
- `MEM_SIZE`, 64: number of 32-bit words in the attached memory; valid word addresses are 0..MEM_SIZE-1.
- `MAX_BURST`, 4: maximum consecutive grants one port may hold under lock; range 1..255.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `pN_req`  in  1  port N (N = 0, 1) access request; held with its qualifiers until `pN_gnt`.
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_lock`  in  1  request to keep ownership for the next access.
- `pN_addr`  in  32  word address.
- `pN_wdata`  in  32  write data.
- `pN_gnt`  out  1  combinational grant; the access is accepted in any cycle with `pN_req & pN_gnt`.
- `pN_rvalid`  out  1  one-cycle response pulse, the cycle after acceptance.
- `pN_rdata`  out  32  read data, valid with `pN_rvalid`.
- `pN_err`  out  1  address out of range, valid with `pN_rvalid`.
- `mem_we`  out  1  to dmem `WE`.
- `mem_a`  out  32  to dmem `A`.
- `mem_wd`  out  32  to dmem `WD`.
- `mem_rd`  in  32  from dmem `RD` (combinational read).

## Operation
- At most one of `p0_gnt`/`p1_gnt` is high per cycle. Neither is high without its own `req`.
- The memory signals are driven from the granted port. When no port is granted: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Range check: `addr >= MEM_SIZE` is out of range. The access is still granted. `mem_we` is forced to 0 and `mem_a` to 0. The response carries `err`=1 and `rdata`=0.
- Response register: captures `mem_rd` for in-range reads and 0 for writes. It drives only the port that was granted.
- Arbitration state: `last` (the last granted port) and an FSM with states ARB, LOCK0 and LOCK1, plus an 8-bit `burst_cnt`.
- ARB:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port that is not `last` is granted.
  - On a grant with `lock`=1 and MAX_BURST>1: go to LOCKn with `burst_cnt`=1.
  - On any other grant: stay in ARB.
- LOCKn, owner requesting:
  - The owner is granted unconditionally and `burst_cnt` increments.
  - Go to ARB if the owner's `lock`=0 or the new count equals MAX_BURST. Otherwise stay in LOCKn.
- LOCKn, owner not requesting: the lock is released in the same cycle and the cycle is arbitrated exactly as in ARB. This includes starting a new lock.
- `last` updates on every grant. Leaving a lock therefore favours the other port on the next tie.

## Timing
- Grant is combinational in the request cycle. The memory write occurs on that cycle's rising edge.
- Response latency is exactly 1 cycle. `rvalid` is a single-cycle pulse. `rdata` and `err` hold their value until the next response to the same port.
- Throughput is 1 access per cycle in total. Back-to-back grants to the same port produce back-to-back `rvalid`.
- Reset values (applied asynchronously while `reset`=0):
  - All `rvalid`, `err` and `rdata` outputs are 0.
  - State is ARB, `burst_cnt`=0, `last`=1, so port 0 wins the first tie.
  - Both `gnt` outputs are 0 and `mem_we` is 0 while `reset`=0.
- Reset during a burst or with a response pending: the pending `rvalid` is dropped, the lock is cleared, and no memory write is issued during reset.
- `burst_cnt` never exceeds MAX_BURST. If MAX_BURST=1, locks have no effect.

## Test plan
- Single read: preload mem[5]=0xDEADBEEF; `p0_req` with addr 5 and we=0 → `p0_gnt` in the same cycle; next cycle `p0_rvalid`=1, `p0_rdata`=0xDEADBEEF, `p0_err`=0.
- Contention after reset: both ports request reads every cycle for 4 cycles → grants go 0,1,0,1 and each `rvalid` reaches the correct port one cycle later.
- Locked burst, MAX_BURST=4: p0 holds lock=1 with p1 requesting → p0 granted for 4 cycles, then p1; p0 writes of 1..4 to addresses 0..3 read back correctly.
- Out of range, MAX_BURST=4, MEM_SIZE=64: p1 write to addr 64 with wdata 0x1234 → `mem_we` stays 0, memory is unchanged, `p1_err`=1 with `p1_rvalid`, `p1_rdata`=0.
- Lock release: p0 locks, then drops `req` for one cycle while p1 requests → p1 granted in that cycle.
- Async reset mid-burst: assert `reset`=0 between clock edges during a p0 lock → all outputs go to 0 immediately; after release, a tie grants port 0.
